dma_block_mover: RTL and testbench

- Custom-instruction-controlled DMA engine that copies word blocks between system bus memory and the 512×32 CI scratchpad. It uses the scratchpad's second port (port B).
- Sits between the bus arbiter (as a burst master) and the scratchpad RAM.
- The CPU programs addresses and sizes through single-cycle CI accesses, starts a transfer, then polls status.

---
 rtl/dma_block_mover_if.sv | 53 +++++
 rtl/dma_block_mover.sv | 195 +++++++++++++++++++
 tb/tb_dma_block_mover.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_block_mover_if.sv
// CI, bus-master and scratchpad port-B signal bundle for the block mover.
// Latency: none, this is wiring only.
// Backpressure: carries busyIn/transactionGranted from the bus side to the mover.
interface dma_block_mover_if;
  // custom-instruction access
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;
  // bus master
  logic        requestTransaction;
  logic        transactionGranted;
  logic        beginTransaction;
  logic [31:0] addressDataOut;
  logic        readNotWrite;
  logic [7:0]  burstSize;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busyIn;
  logic        busErrorIn;
  // scratchpad port B
  logic [8:0]  memAddress;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  modport master (
    input  start, ciN, valueA, valueB,
    output done, result,
    output requestTransaction, beginTransaction, addressDataOut, readNotWrite,
    output burstSize, dataValidOut, endTransactionOut,
    input  transactionGranted, addressDataIn, dataValidIn, endTransactionIn,
    input  busyIn, busErrorIn,
    output memAddress, memWriteEnable, memWriteData,
    input  memReadData
  );

  modport slave (
    output start, ciN, valueA, valueB,
    input  done, result,
    input  requestTransaction, beginTransaction, addressDataOut, readNotWrite,
    input  burstSize, dataValidOut, endTransactionOut,
    output transactionGranted, addressDataIn, dataValidIn, endTransactionIn,
    output busyIn, busErrorIn,
    input  memAddress, memWriteEnable, memWriteData,
    output memReadData
  );
endinterface

// File: rtl/dma_block_mover.sv
// CI-programmed DMA copying word blocks between bus memory and the scratchpad (port B).
// Latency: CI access completes in the same cycle; read beats land in the scratchpad the cycle they arrive.
// Backpressure: busyIn stalls write beats with data held; bursts wait for transactionGranted.
module dma_block_mover #(
  parameter logic [7:0] customId = 8'h01,
  parameter logic [7:0] maxBurst = 8'd15
) (
  input  logic             clock,
  input  logic             reset,
  dma_block_mover_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_BEGIN, S_RDATA, S_WPREF, S_WDATA, S_WEND, S_END_CHECK, S_ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] bus_addr;
  logic [8:0]  mem_addr;
  logic [9:0]  block_size;
  logic [7:0]  burst_len;
  logic        err_flag;
  logic        dir_read;
  logic [31:0] cur_bus;
  logic [8:0]  cur_mem;
  logic [9:0]  remaining;
  logic [8:0]  beats_left;
  logic [31:0] held;
  logic        fresh;
  logic        wr_open;

  logic        active, ci_wr, busy, go, err_hit, rd_beat, wr_beat;
  logic [2:0]  sel;
  logic [8:0]  burst_plus;
  logic [9:0]  beats, beats_m1;
  logic [31:0] rd_data;
  logic        unused_bits;

  // reset also gates the CI strobe so done/result are low while held in reset
  assign active      = reset & bus.start & (bus.ciN == customId);
  assign sel         = bus.valueA[12:10];
  assign ci_wr       = active & bus.valueA[9];
  assign busy        = (state != S_IDLE);
  assign go          = ci_wr & (sel == 3'd5) & ~busy & (bus.valueB[1:0] != 2'b00) & (block_size != 10'd0);
  assign err_hit     = bus.busErrorIn & (state != S_IDLE) & (state != S_ERROR);
  assign rd_beat     = (state == S_RDATA) & bus.dataValidIn & (beats_left != 9'd0) & ~bus.busErrorIn;
  assign wr_beat     = (state == S_WDATA) & ~bus.busyIn & ~bus.busErrorIn;
  assign burst_plus  = {1'b0, burst_len} + 9'd1;
  assign beats       = ({1'b0, burst_plus} < remaining) ? {1'b0, burst_plus} : remaining;
  assign beats_m1    = beats - 10'd1;
  assign bus.done    = active;
  assign bus.result  = active ? rd_data : 32'd0;
  // register-select and data bits outside the decoded fields carry no meaning
  assign unused_bits = ^{bus.valueA[31:13], bus.valueA[8:0], beats_m1[9:8]};

  // CI read mux; reflects pre-edge state so a poll racing completion sees the old status
  always_comb begin
    rd_data = 32'd0;
    case (sel)
      3'd1:    rd_data = bus_addr;
      3'd2:    rd_data = {23'd0, mem_addr};
      3'd3:    rd_data = {22'd0, block_size};
      3'd4:    rd_data = {24'd0, burst_len};
      3'd5:    rd_data = {30'd0, err_flag, busy};
      default: rd_data = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and bus/scratchpad outputs
  always_comb begin
    state_nxt             = state;
    bus.requestTransaction = 1'b0;
    bus.beginTransaction  = 1'b0;
    bus.addressDataOut    = 32'd0;
    bus.readNotWrite      = 1'b0;
    bus.burstSize         = 8'd0;
    bus.dataValidOut      = 1'b0;
    bus.endTransactionOut = 1'b0;
    bus.memAddress        = 9'd0;
    bus.memWriteEnable    = 1'b0;
    bus.memWriteData      = 32'd0;
    case (state)
      S_IDLE: if (go) state_nxt = S_REQ;
      S_REQ: begin
        bus.requestTransaction = 1'b1;
        if (bus.transactionGranted) state_nxt = S_BEGIN;
      end
      S_BEGIN: begin
        bus.requestTransaction = 1'b1;
        bus.beginTransaction   = 1'b1;
        bus.addressDataOut     = cur_bus;
        bus.readNotWrite       = dir_read;
        bus.burstSize          = beats_m1[7:0];
        state_nxt              = dir_read ? S_RDATA : S_WPREF;
      end
      S_RDATA: begin
        bus.requestTransaction = 1'b1;
        bus.memAddress         = cur_mem;
        bus.memWriteEnable     = rd_beat;
        bus.memWriteData       = bus.addressDataIn;
        if (bus.endTransactionIn) state_nxt = S_END_CHECK;
      end
      S_WPREF: begin
        bus.requestTransaction = 1'b1;
        bus.memAddress         = cur_mem;
        state_nxt              = S_WDATA;
      end
      S_WDATA: begin
        // the address one ahead is always presented so the next word is ready the
        // cycle after an accepted beat; it does not move during a stall
        bus.requestTransaction = 1'b1;
        bus.dataValidOut       = 1'b1;
        bus.addressDataOut     = fresh ? bus.memReadData : held;
        bus.memAddress         = cur_mem + 9'd1;
        if (wr_beat && (beats_left == 9'd1)) state_nxt = S_WEND;
      end
      S_WEND: begin
        bus.requestTransaction = 1'b1;
        bus.endTransactionOut  = 1'b1;
        state_nxt              = S_END_CHECK;
      end
      S_END_CHECK: state_nxt = (remaining == 10'd0) ? S_IDLE : S_REQ;
      S_ERROR: begin
        bus.endTransactionOut = wr_open;
        state_nxt             = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (err_hit) state_nxt = S_ERROR;
  end

  // Config registers, working counters and the write-beat holding register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_addr   <= 32'd0;
      mem_addr   <= 9'd0;
      block_size <= 10'd0;
      burst_len  <= 8'd0;
      err_flag   <= 1'b0;
      dir_read   <= 1'b0;
      cur_bus    <= 32'd0;
      cur_mem    <= 9'd0;
      remaining  <= 10'd0;
      beats_left <= 9'd0;
      held       <= 32'd0;
      fresh      <= 1'b0;
      wr_open    <= 1'b0;
    end else begin
      if (ci_wr && !busy) begin
        case (sel)
          3'd1:    bus_addr   <= {bus.valueB[31:2], 2'b00};
          3'd2:    mem_addr   <= bus.valueB[8:0];
          3'd3:    block_size <= bus.valueB[9:0];
          3'd4:    burst_len  <= (bus.valueB[7:0] > maxBurst) ? maxBurst : bus.valueB[7:0];
          default: ;
        endcase
      end
      if (go) begin
        err_flag  <= 1'b0;
        dir_read  <= bus.valueB[0];
        cur_bus   <= bus_addr;
        cur_mem   <= mem_addr;
        remaining <= block_size;
      end
      if (state == S_BEGIN) beats_left <= beats[8:0];
      if (rd_beat || wr_beat) begin
        cur_mem    <= cur_mem + 9'd1;
        cur_bus    <= cur_bus + 32'd4;
        remaining  <= remaining - 10'd1;
        beats_left <= beats_left - 9'd1;
      end
      if (state == S_WPREF) begin
        fresh <= 1'b1;
      end else if (state == S_WDATA) begin
        if (wr_beat) begin
          fresh <= 1'b1;
        end else if (fresh) begin
          held  <= bus.memReadData;
          fresh <= 1'b0;
        end
      end
      if (err_hit) begin
        err_flag <= 1'b1;
        wr_open  <= (state == S_WPREF) || (state == S_WDATA) || ((state == S_BEGIN) && !dir_read);
      end
    end
  end

endmodule

// File: tb/tb_dma_block_mover.sv
// Scoreboard bench for dma_block_mover: a bus slave and scratchpad model drive the DUT,
// expected CI reads, bus begins, scratchpad writes and write beats are queued by the
// stimulus thread and consumed by a monitor sampling on the falling edge.
module tb_dma_block_mover;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dma_block_mover_if bus();
  dma_block_mover #(.customId(8'h01), .maxBurst(8'd15)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int end_cnt = 0;
  bit poll = 1'b0;
  int err_at = 0;
  bit toggle_en = 1'b0;

  logic [63:0] q_ci[$];
  logic [63:0] q_beg[$];
  logic [63:0] q_mw[$];
  logic [63:0] q_wb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scratchpad port B model: word i preloaded with B000_0000|i, 1-cycle read latency
  logic [31:0] mem [512];
  bit mem_ready = 1'b0;
  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hB000_0000 | 32'(i);
      mem_ready <= 1'b1;
    end else if (bus.memWriteEnable) begin
      mem[bus.memAddress] <= bus.memWriteData;
    end
    bus.memReadData <= mem[bus.memAddress];
  end

  // bus slave: grants any request, returns 5A00_0000|address for read beats
  initial begin
    int rd_left;
    int beat_no;
    logic [31:0] baddr;
    rd_left = 0; beat_no = 0; baddr = 32'd0;
    bus.transactionGranted = 1'b0; bus.addressDataIn = 32'd0; bus.dataValidIn = 1'b0;
    bus.endTransactionIn = 1'b0; bus.busyIn = 1'b0; bus.busErrorIn = 1'b0;
    forever begin
      @(posedge clock); #1;
      bus.transactionGranted = bus.requestTransaction;
      bus.busErrorIn = 1'b0;
      if (rd_left > 0) begin
        beat_no++;
        if (err_at != 0 && beat_no == err_at) begin
          bus.busErrorIn = 1'b1; bus.dataValidIn = 1'b0; bus.endTransactionIn = 1'b0;
          rd_left = 0;
        end else begin
          bus.dataValidIn = 1'b1;
          bus.addressDataIn = 32'h5A00_0000 | baddr;
          baddr = baddr + 32'd4;
          bus.endTransactionIn = (rd_left == 1);
          rd_left--;
        end
      end else begin
        bus.dataValidIn = 1'b0; bus.endTransactionIn = 1'b0;
      end
      if (bus.beginTransaction && bus.readNotWrite) begin
        rd_left = int'(bus.burstSize) + 1;
        beat_no = 0;
        baddr = bus.addressDataOut;
      end
      bus.busyIn = toggle_en ? ~bus.busyIn : 1'b0;
    end
  end

  // monitor: pops the matching queue whenever the DUT presents an output event
  initial forever begin
    @(negedge clock);
    if (bus.done && !bus.valueA[9] && !poll) begin
      if (q_ci.size() == 0) check("ci_read_unexpected", 64'(bus.result), 64'hDEAD);
      else check("ci_read", 64'(bus.result), q_ci.pop_front());
    end
    if (!bus.done) check("result_when_idle", 64'(bus.result), 64'd0);
    if (bus.beginTransaction) begin
      if (q_beg.size() == 0) check("begin_unexpected", {23'd0, bus.readNotWrite, bus.burstSize, bus.addressDataOut}, 64'hDEAD);
      else check("begin", {23'd0, bus.readNotWrite, bus.burstSize, bus.addressDataOut}, q_beg.pop_front());
    end
    if (bus.memWriteEnable) begin
      if (q_mw.size() == 0) check("memw_unexpected", {23'd0, bus.memAddress, bus.memWriteData}, 64'hDEAD);
      else check("memw", {23'd0, bus.memAddress, bus.memWriteData}, q_mw.pop_front());
    end
    if (bus.dataValidOut && !bus.busyIn) begin
      if (q_wb.size() == 0) check("wbeat_unexpected", 64'(bus.addressDataOut), 64'hDEAD);
      else check("wbeat", 64'(bus.addressDataOut), q_wb.pop_front());
    end
    if (bus.endTransactionOut) end_cnt++;
  end

  task automatic ci_op(input logic [2:0] sel, input logic wr, input logic [31:0] data,
                       input bit is_poll, output logic [31:0] res);
    @(posedge clock); #1;
    poll = is_poll;
    bus.start = 1'b1; bus.ciN = 8'h01; bus.valueA = {19'd0, sel, wr, 9'd0}; bus.valueB = data;
    @(negedge clock);
    res = bus.result;
    if (!is_poll) check("done_high", 64'(bus.done), 64'd1);
    @(posedge clock); #1;
    bus.start = 1'b0; bus.valueA = 32'd0; bus.valueB = 32'd0;
    #1;
    if (!is_poll) check("done_one_cycle", 64'(bus.done), 64'd0);
    poll = 1'b0;
  endtask

  task automatic ci_write(input logic [2:0] sel, input logic [31:0] data);
    logic [31:0] r;
    ci_op(sel, 1'b1, data, 1'b0, r);
  endtask

  task automatic ci_read(input logic [2:0] sel, input logic [31:0] exp);
    logic [31:0] r;
    q_ci.push_back(64'(exp));
    ci_op(sel, 1'b0, 32'd0, 1'b0, r);
  endtask

  task automatic wait_idle();
    logic [31:0] r;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ci_op(3'd5, 1'b0, 32'd0, 1'b1, r);
      if (r[0] == 1'b0) begin ok = 1'b1; break; end
    end
    check("wait_idle", 64'(ok), 64'd1);
  endtask

  task automatic exp_begin(input logic rnw, input logic [7:0] bs, input logic [31:0] addr);
    q_beg.push_back({23'd0, rnw, bs, addr});
  endtask

  task automatic exp_memw(input logic [8:0] a, input logic [31:0] d);
    q_mw.push_back({23'd0, a, d});
  endtask

  initial begin
    bit seen;
    bus.start = 1'b0; bus.ciN = 8'h00; bus.valueA = 32'd0; bus.valueB = 32'd0;
    #12;
    check("rst_request", 64'(bus.requestTransaction), 64'd0);
    check("rst_begin", 64'(bus.beginTransaction), 64'd0);
    check("rst_memwe", 64'(bus.memWriteEnable), 64'd0);
    check("rst_addr_out", 64'(bus.addressDataOut), 64'd0);
    @(negedge clock); reset = 1'b1;

    // reset values
    for (int s = 1; s <= 5; s++) ci_read(3'(s), 32'd0);

    // config readback, with address alignment and burst clamp
    ci_write(3'd1, 32'h1003);
    ci_write(3'd2, 32'd5);
    ci_write(3'd3, 32'd3);
    ci_write(3'd4, 32'h40);
    ci_read(3'd1, 32'h1000);
    ci_read(3'd2, 32'd5);
    ci_read(3'd3, 32'd3);
    ci_read(3'd4, 32'd15);

    // other CI number: no completion
    @(posedge clock); #1;
    bus.start = 1'b1; bus.ciN = 8'h02; bus.valueA = {19'd0, 3'd5, 1'b0, 9'd0};
    @(negedge clock);
    check("foreign_ci_done", 64'(bus.done), 64'd0);
    @(posedge clock); #1;
    bus.start = 1'b0; bus.ciN = 8'h00; bus.valueA = 32'd0;

    // bus -> mem, 20 words in bursts of 8/8/4
    ci_write(3'd3, 32'd20);
    ci_write(3'd4, 32'd7);
    exp_begin(1'b1, 8'd7, 32'h1000);
    exp_begin(1'b1, 8'd7, 32'h1020);
    exp_begin(1'b1, 8'd3, 32'h1040);
    for (int i = 0; i < 20; i++) exp_memw(9'(5 + i), 32'h5A00_1000 + 32'(4 * i));
    ci_write(3'd5, 32'd1);
    wait_idle();
    ci_read(3'd5, 32'd0);

    // mem -> bus across the scratchpad wrap, with stalls every other cycle
    ci_write(3'd1, 32'h8000);
    ci_write(3'd2, 32'd510);
    ci_write(3'd3, 32'd4);
    ci_write(3'd4, 32'd15);
    exp_begin(1'b0, 8'd3, 32'h8000);
    q_wb.push_back(64'h0000_0000_B000_01FE);
    q_wb.push_back(64'h0000_0000_B000_01FF);
    q_wb.push_back(64'h0000_0000_B000_0000);
    q_wb.push_back(64'h0000_0000_B000_0001);
    toggle_en = 1'b1;
    ci_write(3'd5, 32'd2);
    wait_idle();
    toggle_en = 1'b0;
    ci_read(3'd5, 32'd0);

    // bus error on beat 3 of 8
    ci_write(3'd1, 32'h4000);
    ci_write(3'd2, 32'd200);
    ci_write(3'd3, 32'd8);
    ci_write(3'd4, 32'd7);
    err_at = 3;
    exp_begin(1'b1, 8'd7, 32'h4000);
    exp_memw(9'd200, 32'h5A00_4000);
    exp_memw(9'd201, 32'h5A00_4004);
    ci_write(3'd5, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.busErrorIn) begin seen = 1'b1; break; end
    end
    check("err_seen", 64'(seen), 64'd1);
    if (seen) check("req_at_err", 64'(bus.requestTransaction), 64'd1);
    @(negedge clock);
    check("req_dropped", 64'(bus.requestTransaction), 64'd0);
    err_at = 0;
    wait_idle();
    ci_read(3'd5, 32'd2);
    ci_write(3'd3, 32'd1);
    exp_begin(1'b1, 8'd0, 32'h4000);
    exp_memw(9'd200, 32'h5A00_4000);
    ci_write(3'd5, 32'd1);
    ci_read(3'd5, 32'd1);
    wait_idle();
    ci_read(3'd5, 32'd0);

    // ignored starts and config writes
    ci_write(3'd3, 32'd0);
    ci_write(3'd5, 32'd1);
    ci_read(3'd5, 32'd0);
    ci_write(3'd1, 32'h2000);
    ci_write(3'd2, 32'd100);
    ci_write(3'd3, 32'd4);
    exp_begin(1'b1, 8'd3, 32'h2000);
    for (int i = 0; i < 4; i++) exp_memw(9'(100 + i), 32'h5A00_2000 + 32'(4 * i));
    ci_write(3'd5, 32'd1);
    ci_write(3'd1, 32'h3000);
    ci_write(3'd5, 32'd3);
    wait_idle();
    ci_read(3'd1, 32'h2000);
    ci_read(3'd5, 32'd0);

    // asynchronous reset in the middle of a read burst
    ci_write(3'd1, 32'h6000);
    ci_write(3'd2, 32'd300);
    ci_write(3'd3, 32'd8);
    ci_write(3'd4, 32'd7);
    exp_begin(1'b1, 8'd7, 32'h6000);
    exp_memw(9'd300, 32'h5A00_6000);
    exp_memw(9'd301, 32'h5A00_6004);
    ci_write(3'd5, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); #2;
      if (q_mw.size() == 0) begin seen = 1'b1; break; end
    end
    check("mid_burst_reached", 64'(seen), 64'd1);
    reset = 1'b0;
    #1;
    check("arst_request", 64'(bus.requestTransaction), 64'd0);
    check("arst_memwe", 64'(bus.memWriteEnable), 64'd0);
    check("arst_memaddr", 64'(bus.memAddress), 64'd0);
    check("arst_memdata", 64'(bus.memWriteData), 64'd0);
    check("arst_dvalid", 64'(bus.dataValidOut), 64'd0);
    check("arst_addr_out", 64'(bus.addressDataOut), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int s = 1; s <= 5; s++) ci_read(3'(s), 32'd0);

    repeat (4) @(negedge clock);
    check("ci_queue_drained", 64'(q_ci.size()), 64'd0);
    check("begin_queue_drained", 64'(q_beg.size()), 64'd0);
    check("memw_queue_drained", 64'(q_mw.size()), 64'd0);
    check("wbeat_queue_drained", 64'(q_wb.size()), 64'd0);
    check("write_end_count", 64'(end_cnt), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "timeout");
  end
endmodule
